// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - UART receive deframer: start detect, mid-bit sampling,
// optional parity, stop check, and a valid/ready byte output with error flags.
module uart_rx_deframer #(
  parameter int BAUD_DIV = 868,
  parameter int PARITY   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd_filtered,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_parity_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
  localparam logic          ODD_PAR   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state;
  logic          rxd_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_err;
  logic          start_cond;
  logic          strobe;
  logic          counting;

  assign start_cond = (state == S_IDLE) & rxd_prev & ~rxd_filtered;
  assign strobe     = (cnt == '0);
  assign counting   = (state != S_IDLE) && (state != S_BREAK);
  assign rx_busy    = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_prev <= 1'b1;
    end else begin
      rxd_prev <= rxd_filtered;
    end
  end

  // First sample lands half a bit after the edge, every later one a full bit apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start_cond) begin
      cnt <= HALF_LOAD;
    end else if (counting) begin
      cnt <= strobe ? FULL_LOAD : cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      bit_idx       <= '0;
      shreg         <= '0;
      par_err       <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (start_cond) begin
            state <= S_START;
          end
        end
        S_START: begin
          if (strobe) begin
            if (rxd_filtered) begin
              state <= S_IDLE;
            end else begin
              state   <= S_DATA;
              bit_idx <= '0;
              par_err <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (strobe) begin
            shreg   <= {rxd_filtered, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end
          end
        end
        S_PARITY: begin
          if (strobe) begin
            par_err <= ((^shreg) ^ rxd_filtered) != ODD_PAR;
            state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (strobe) begin
            // A completion takes precedence over the plain accept above.
            if (!rx_valid || rx_ready) begin
              rx_data       <= shreg;
              rx_frame_err  <= ~rxd_filtered;
              rx_parity_err <= par_err;
              rx_valid      <= 1'b1;
            end else begin
              rx_overrun <= 1'b1;
            end
            state <= rxd_filtered ? S_IDLE : S_BREAK;
          end
        end
        S_BREAK: begin
          if (rxd_filtered) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

Receive deframer of the uart RS232 interface, directly downstream of the receive-line filter. Consumes the filtered, already-synchronised serial line, detects start bits, samples each bit at mid-bit, checks optional parity and the stop bit, and presents each received byte on a valid/ready handshake with per-byte error flags. Also reports overrun when a byte completes while the previous one is still unconsumed.

## Interface
- BAUD_DIV, 868, clock cycles per bit (100 MHz / 115200); legal range 4..65535
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- clk  in  1  system clock; all logic on its rising edge
- rst_n  in  1  reset, asynchronous assert, active-low; all registers to reset values while low
- rxd_filtered  in  1  filtered serial line, idle high, already synchronous to clk
- rx_data  out  8  received byte, LSB received first; reset 8'h00
- rx_valid  out  1  rx_data/flags hold a byte not yet accepted; reset 0
- rx_ready  in  1  consumer accepts byte when rx_valid & rx_ready
- rx_frame_err  out  1  stop bit of this byte sampled 0; qualified by rx_valid; reset 0
- rx_parity_err  out  1  parity mismatch for this byte (always 0 when PARITY = 0); qualified by rx_valid; reset 0
- rx_overrun  out  1  one-cycle pulse: completed byte discarded; reset 0
- rx_busy  out  1  state != IDLE; reset 0

## Operation
- Edge detect: register rxd_prev (reset 1); start condition = IDLE & rxd_prev & ~rxd_filtered.
- Bit counter: down-counter, width clog2(BAUD_DIV); sample strobe when counter = 0. On start condition load BAUD_DIV/2 − 1 (integer division); on every strobe outside IDLE reload BAUD_DIV − 1.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE -> START on start condition.
- START: on strobe, line 1 -> IDLE (false start, nothing reported); line 0 -> DATA, bit index 0.
- DATA: on strobe, shift line into bit[index]; after index 7 -> PARITY if PARITY != 0, else STOP.
- PARITY: on strobe, parity_err = (^data ^ line) != (PARITY == 1); -> STOP.
- STOP: on strobe, complete the byte (below); line 1 -> IDLE, line 0 -> BREAK.
- BREAK: stay until rxd_filtered = 1, then -> IDLE. No start detection while in BREAK.
- Completion, with nothing held (rx_valid = 0) or held byte accepted in the same cycle: load rx_data, rx_frame_err = ~line, rx_parity_err; rx_valid = 1.
- Completion while rx_valid = 1 & ~rx_ready: new byte dropped; held byte and flags unchanged; rx_overrun = 1 for one cycle.
- rx_valid & rx_ready without completion: rx_valid -> 0 next cycle; rx_data/flags keep their values.
- rx_data and flags are stable while rx_valid = 1.
- rst_n low mid-frame: immediate return to IDLE, rx_valid = 0, partial byte lost. Reception restarts only on a fresh high-to-low edge after release.

## Timing
- Start bit sampled BAUD_DIV/2 cycles after the first cycle rxd_filtered = 0 (counter load counts as cycle 0).
- Each following sample is exactly BAUD_DIV cycles after the previous one.
- rx_valid rises on the clock edge ending the stop-bit strobe cycle. That is BAUD_DIV/2 + 9·BAUD_DIV cycles after the start edge, plus BAUD_DIV if PARITY != 0.
- Back-to-back frames: the next start edge is detected in the cycle after the STOP -> IDLE transition, so minimum stop length = BAUD_DIV/2 + 1 cycles.
- Handshake: one byte per cycle; combinational path rx_ready -> rx_valid not allowed (registered).

## Test plan
- BAUD_DIV=16, PARITY=0, rx_ready=1, send 0x55 with stop=1 -> rx_valid pulses 1 cycle, rx_data=0x55, both error flags 0, at start-edge + 152 cycles.
- PARITY=2, send 0xA7 with parity bit 0 (wrong) -> rx_data=0xA7, rx_parity_err=1. Repeat with parity bit 1 -> rx_parity_err=0.
- 4-cycle low glitch on idle line -> false start: no rx_valid, rx_busy back to 0 at edge + 9 cycles.
- Line held low 20 bit times (break) -> one byte 0x00 with rx_frame_err=1; stays in BREAK until line high; no further bytes; next real frame 0x3C received correctly.
- rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_data stays 0x11, rx_overrun pulses 1 cycle at the second stop strobe. Then rx_ready=1 -> rx_valid drops next cycle.
- rst_n pulsed low during DATA bit 4 of a frame -> rx_valid=0, rx_busy=0 immediately; remainder of the frame produces no byte until the next start edge.
